// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial add/subtract sequencer.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        SA_IDLE = 2'd0,
        SA_RUN  = 2'd1,
        SA_DONE = 2'd2
    } sa_state_t;

    localparam int SA_DEFAULT_WIDTH = 8;

    // The counter must be able to hold WIDTH itself after the last increment.
    function automatic int sa_cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// Single-bit full adder cell shared by every bit position of the serial sequencer.
module fullAdder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer: one full adder, LSB first, valid/ready on both sides.
// Optional feature macro: SERIAL_ADDER_CTRL_OVERFLOW_EN (two's-complement overflow flag).
//
// state   | meaning
// SA_IDLE | waiting for operands, InReady high
// SA_RUN  | one operand bit per clock through the full adder
// SA_DONE | result held, OutValid high until OutReady
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SA_DEFAULT_WIDTH
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Sub,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Result,
    output logic             CarryOut,
    output logic             Overflow
);

    localparam int CW = sa_cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    sa_state_t state, state_next;

    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic             fa_sum;
    logic             fa_cout;
    logic             last_bit;

    fullAdder u_fa (
        .a    (opa[0]),
        .b    (opb[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign last_bit = (cnt == LAST);
    // Written as a shift/OR so WIDTH=1 needs no empty slice.
    assign acc_next = (acc >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= SA_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        InReady    = 1'b0;
        OutValid   = 1'b0;
        case (state)
            SA_IDLE: begin
                InReady = 1'b1;
                if (InValid) begin
                    state_next = SA_RUN;
                end
            end
            SA_RUN: begin
                if (last_bit) begin
                    state_next = SA_DONE;
                end
            end
            SA_DONE: begin
                OutValid = 1'b1;
                if (OutReady) begin
                    state_next = SA_IDLE;
                end
            end
            default: state_next = SA_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cnt      <= '0;
            carry    <= 1'b0;
            opa      <= '0;
            opb      <= '0;
            acc      <= '0;
            Result   <= '0;
            CarryOut <= 1'b0;
        end else begin
            case (state)
                SA_IDLE: begin
                    if (InValid) begin
                        opa   <= A;
                        opb   <= Sub ? ~B : B;
                        carry <= Sub;
                        cnt   <= '0;
                    end
                end
                SA_RUN: begin
                    opa   <= opa >> 1;
                    opb   <= opb >> 1;
                    acc   <= acc_next;
                    carry <= fa_cout;
                    cnt   <= cnt + 1'b1;
                    if (last_bit) begin
                        Result   <= acc_next;
                        CarryOut <= fa_cout;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_ADDER_CTRL_OVERFLOW_EN
    logic overflow_q;

    // In the last RUN cycle the carry flop holds the carry into the MSB.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            overflow_q <= 1'b0;
        end else if (state == SA_RUN && last_bit) begin
            overflow_q <= carry ^ fa_cout;
        end
    end

    assign Overflow = overflow_q;
`else
    assign Overflow = 1'b0;
`endif

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial add/subtract sequencer built around a single `fullAdder` cell. It accepts two WIDTH-bit operands through a valid/ready handshake and feeds them to the adder one bit per clock, LSB first, keeping the carry in a flip-flop between cycles. It returns the result through a second valid/ready handshake. It sits between a register-file or operand source and any consumer that can trade latency for one adder cell instead of a WIDTH-bit ripple chain.

## Interface
Parameters:
- `WIDTH`, default 8: operand and result width; legal range 1 to 32.

Ports:
- `Clk`, input, 1: single clock; all state updates on the rising edge.
- `Rst`, input, 1: asynchronous, active-high reset.
- `InValid`, input, 1: operands and `Sub` are valid.
- `InReady`, output, 1: block can accept operands.
- `A`, input, WIDTH: first operand.
- `B`, input, WIDTH: second operand.
- `Sub`, input, 1: 0 computes A+B; 1 computes A−B, as A + ~B + 1.
- `OutValid`, output, 1: `Result`, `CarryOut` and `Overflow` are valid.
- `OutReady`, input, 1: consumer takes the result.
- `Result`, output, WIDTH: sum or difference.
- `CarryOut`, output, 1: carry out of the MSB; for subtraction, 1 means no borrow.
- `Overflow`, output, 1: two's-complement overflow.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- **IDLE:**
  - `InReady`=1.
  - On `InValid`&&`InReady`:
    - latch A into shift register `opA`;
    - latch B (or ~B when `Sub`=1) into shift register `opB`;
    - set the carry flip-flop to `Sub`;
    - clear the bit counter `cnt`;
    - go to RUN.
- **RUN:**
  - `InReady`=0.
  - Each cycle, `fullAdder`(`opA[0]`, `opB[0]`, carry) produces Sum and Cout.
  - Sum shifts into the MSB of the accumulating shift register `acc`.
  - `opA` and `opB` shift right.
  - The carry flip-flop takes Cout.
  - `cnt` increments.
  - When `cnt`==WIDTH−1:
    - copy the completed `acc` value into the `Result` register;
    - load the final carry into `CarryOut`;
    - compute `Overflow`;
    - go to DONE.
- **DONE:**
  - `OutValid`=1.
  - `Result`, `CarryOut` and `Overflow` are held stable.
  - On `OutReady`=1, go to IDLE.
  - New operands are not accepted in the same cycle; `InReady` rises the cycle after.
- `Overflow` = carry into the MSB XOR carry out of the MSB.
  - The carry into the MSB is the carry flip-flop value during the final RUN cycle.
- Results wrap modulo 2^WIDTH.
- `cnt` is $clog2(WIDTH+1) bits wide.
- WIDTH=1 is legal: exactly one RUN cycle.
- Operand inputs are ignored outside the accepting IDLE cycle.
- `InValid` held high while busy has no effect.
- **Reset, at any time including mid-RUN:**
  - state=IDLE; `cnt`, carry, `opA`, `opB`, `acc` and `Result` cleared;
  - `CarryOut`=0, `Overflow`=0, `OutValid`=0, `InReady`=1 once `Rst` deasserts;
  - any in-flight operation is discarded.

## Timing
- The accepting edge is edge 0.
- RUN processes bit i in the cycle after edge i, for i = 0 … WIDTH−1.
- `OutValid` rises after edge WIDTH: latency is exactly WIDTH cycles from acceptance to valid result.
- The minimum issue interval is WIDTH+2 cycles: accept, WIDTH RUN cycles, one DONE cycle with `OutReady`=1, then IDLE.
  - Re-acceptance occurs on the IDLE edge.
- `OutReady` is sampled only in DONE. Back-pressure holds DONE indefinitely with outputs stable.
- `InReady` and `OutValid` are registered-state decodes with no combinational path from `InValid` or `OutReady`.
- Reset is asynchronous.
  - Outputs reach reset values without a clock edge.
  - Reset deassertion is assumed synchronized externally.

## Configuration
- Macro: `SERIAL_ADDER_CTRL_OVERFLOW_EN`.
- **Defined:**
  - the MSB carry-in is captured;
  - `Overflow` is computed as above and registered on entry to DONE.
- **Undefined:**
  - the capture logic is removed;
  - the `Overflow` port remains and is tied to 0;
  - all other behaviour is unchanged.

## Structure
- **Package `serial_adder_pkg`:**
  - state enum `sa_state_t` {SA_IDLE, SA_RUN, SA_DONE};
  - localparam `SA_DEFAULT_WIDTH`=8;
  - a function returning the counter width, $clog2(WIDTH+1).
- **Sub-module:** one `fullAdder` instance for the per-bit arithmetic. All sequencing, shifting and handshake logic lives in `serial_adder_ctrl`.

## Test plan
All scenarios use WIDTH=8 unless stated.
- **Basic add:** A=0x35, B=0x4A, Sub=0 → after 8 cycles `OutValid`=1, `Result`=0x7F, `CarryOut`=0, `Overflow`=0.
- **Unsigned wrap:** A=0xFF, B=0x01, Sub=0 → `Result`=0x00, `CarryOut`=1, `Overflow`=0.
- **Signed overflow:** A=0x7F, B=0x01 → `Result`=0x80, `Overflow`=1 with the macro defined, 0 without.
- **Subtract with borrow:** A=0x10, B=0x20, Sub=1 → `Result`=0xF0, `CarryOut`=0.
- **Subtract, no borrow:** A=0x20, B=0x10, Sub=1 → `Result`=0x10, `CarryOut`=1.
- **Back-pressure:** hold `OutReady`=0 for 5 cycles in DONE → outputs stable, `InReady`=0; raise `OutReady` → `InReady`=1 the next cycle.
- **Mid-RUN reset:** assert `Rst` at bit 4 → `OutValid`=0, `InReady`=1 immediately; the next operation A=0x01, B=0x01 yields 0x02.
- **WIDTH=1 boundary:** A=1, B=1 → `Result`=0, `CarryOut`=1, latency 1 cycle.
